id_regfile_mp: RTL

ID_REGFILE_MP -- requirements
Module: id_regfile_mp

---
 rtl/id_pkg.sv | 12 +
 rtl/id_regfile_dump_ctrl.sv | 69 ++++++
 rtl/id_regfile_mp.sv | 94 +++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared constants for the multi-port register file and its debug dump engine.
package id_pkg;

  localparam int NB_DATA_DEF  = 32;
  localparam int NB_REG_DEF   = 5;
  localparam int SIZE_REG_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

endpackage

// File: rtl/id_regfile_dump_ctrl.sv
// Debug dump sequencer: walks every register index and presents one
// valid/ready beat per register, holding each beat stable until accepted.
module id_regfile_dump_ctrl
  import id_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_REG   = NB_REG_DEF,
  parameter int SIZE_REG = SIZE_REG_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dump_start,
  input  logic               dump_ready,
  input  logic [NB_DATA-1:0] index_data,
  output logic [NB_REG-1:0]  index,
  output logic               dump_valid,
  output logic [NB_REG-1:0]  dump_addr,
  output logic [NB_DATA-1:0] dump_data,
  output logic               dump_last,
  output logic               busy
);

  localparam logic [NB_REG-1:0] LAST_IDX = NB_REG'(SIZE_REG - 1);

  logic [1:0] state;

  // The beat is captured in LOAD, so later register writes cannot disturb a
  // beat that is waiting in SEND for the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      dump_addr <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dump_start) begin
            state <= ST_LOAD;
            index <= '0;
          end
        end
        ST_LOAD: begin
          dump_data <= index_data;
          dump_addr <= index;
          dump_last <= (index == LAST_IDX);
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (dump_ready) begin
            if (dump_last) begin
              state     <= ST_IDLE;
              dump_last <= 1'b0;
            end else begin
              index <= index + NB_REG'(1);
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dump_valid = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);

endmodule

// File: rtl/id_regfile_mp.sv
// Register file with N_RD combinational read ports, write-through bypass,
// optional hardwired-zero r0 and a handshaked debug dump of all registers.
module id_regfile_mp
  import id_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_REG   = NB_REG_DEF,
  parameter int SIZE_REG = SIZE_REG_DEF,
  parameter int N_RD     = 2,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [N_RD*NB_REG-1:0]  i_rd_addr,
  output logic [N_RD*NB_DATA-1:0] o_rd_data,
  input  logic                    i_wr_en,
  input  logic [NB_REG-1:0]       i_wr_addr,
  input  logic [NB_DATA-1:0]      i_wr_data,
  input  logic                    i_dump_start,
  output logic                    o_dump_valid,
  input  logic                    i_dump_ready,
  output logic [NB_REG-1:0]       o_dump_addr,
  output logic [NB_DATA-1:0]      o_dump_data,
  output logic                    o_dump_last,
  output logic                    o_busy
);

  logic [NB_DATA-1:0] regs [SIZE_REG];
  logic [NB_REG-1:0]  dump_index;
  logic [NB_DATA-1:0] dump_index_data;
  logic               wr_ok;

  function automatic logic writable(input int r);
    return !(ZERO_R0 && r == 0);
  endfunction

  assign wr_ok = i_wr_en & i_enable & ~i_reset;

  // Out-of-range write addresses simply match no register.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < SIZE_REG; r++) begin
      if (i_reset)
        regs[r] <= NB_DATA'(r);
      else if (wr_ok && writable(r) && i_wr_addr == NB_REG'(r))
        regs[r] <= i_wr_data;
    end
  end

  // One extra read port serves the dump engine so it sees the same bypass.
  for (genvar k = 0; k <= N_RD; k++) begin : g_rd
    logic [NB_REG-1:0]  addr;
    logic [NB_DATA-1:0] val;

    if (k < N_RD) begin : g_port
      assign addr = i_rd_addr[k*NB_REG +: NB_REG];
      assign o_rd_data[k*NB_DATA +: NB_DATA] = val;
    end else begin : g_dump
      assign addr = dump_index;
      assign dump_index_data = val;
    end

    always_comb begin
      val = '0;
      for (int r = 0; r < SIZE_REG; r++) begin
        if (addr == NB_REG'(r) && writable(r)) begin
          if (wr_ok && i_wr_addr == addr)
            val = i_wr_data;
          else
            val = regs[r];
        end
      end
    end
  end

  id_regfile_dump_ctrl #(
    .NB_DATA  (NB_DATA),
    .NB_REG   (NB_REG),
    .SIZE_REG (SIZE_REG)
  ) u_dump_ctrl (
    .clk        (i_clk),
    .reset      (i_reset),
    .dump_start (i_dump_start),
    .dump_ready (i_dump_ready),
    .index_data (dump_index_data),
    .index      (dump_index),
    .dump_valid (o_dump_valid),
    .dump_addr  (o_dump_addr),
    .dump_data  (o_dump_data),
    .dump_last  (o_dump_last),
    .busy       (o_busy)
  );

endmodule
